aes_round_tail: RTL and testbench

//  Completes one AES-128 encryption round after SubBytes: ShiftRows -> MixColumns -> AddRoundKey.

---
 rtl/aes_round_tail.sv | 166 ++++++++++++++++
 tb/tb_aes_round_tail.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_tail.sv
// aes_round_tail: second half of one AES-128 encryption round.
// The substituted state is passed through ShiftRows, then MixColumns (skipped
// on the final round), then AddRoundKey. Up to two stages are held in a
// valid/ready pipeline with full backpressure.
// Byte 0 = s(0,0) sits in [127:120]; bytes run column-major.
module aes_round_tail #(
    parameter int unsigned REG_MIX = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Row r rotates left by r positions: s'(r,c) = s(r,(c+r) mod 4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
            end
        end
        shift_rows = r;
    endfunction

    // One column times the circulant matrix [02 03 01 01].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        mix_column = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                      a0 ^ x1 ^ x2 ^ a2 ^ a3,
                      a0 ^ a1 ^ x2 ^ x3 ^ a3,
                      x0 ^ a0 ^ a1 ^ a2 ^ x3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
        end
        mix_columns = r;
    endfunction

    logic [127:0] sr_state;
    logic [127:0] mix_comb;

    // Stage-A payload: ShiftRows always, MixColumns except on the final round.
    always_comb begin
        sr_state = shift_rows(in_data);
        mix_comb = in_last ? sr_state : mix_columns(sr_state);
    end

    // Interface between the optional stage A and stage B.
    logic         src_valid;
    logic [127:0] src_mix;
    logic [127:0] src_key;
    logic         a_busy;

    logic         b_valid_q, b_valid_d;
    logic [127:0] b_data_q, b_data_d;
    logic         b_can_load;

    // B can take new data when empty or when its block leaves this cycle.
    always_comb begin
        b_can_load = !b_valid_q || out_ready;
    end

    generate
        if (REG_MIX != 0) begin : g_stage_a
            logic         a_valid_q, a_valid_d;
            logic [127:0] a_mix_q, a_mix_d;
            logic [127:0] a_key_q, a_key_d;
            logic         a_load;

            // A loads when empty or when its block moves into B this cycle.
            always_comb begin
                a_load    = !a_valid_q || b_can_load;
                a_valid_d = a_valid_q;
                a_mix_d   = a_mix_q;
                a_key_d   = a_key_q;
                if (a_load) begin
                    a_valid_d = in_valid;
                    if (in_valid) begin
                        a_mix_d = mix_comb;
                        a_key_d = in_key;
                    end
                end
            end

            // Stage A registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_valid_q <= 1'b0;
                    a_mix_q   <= '0;
                    a_key_q   <= '0;
                end else begin
                    a_valid_q <= a_valid_d;
                    a_mix_q   <= a_mix_d;
                    a_key_q   <= a_key_d;
                end
            end

            assign in_ready  = a_load;
            assign src_valid = a_valid_q;
            assign src_mix   = a_mix_q;
            assign src_key   = a_key_q;
            assign a_busy    = a_valid_q;
        end else begin : g_no_stage_a
            assign in_ready  = b_can_load;
            assign src_valid = in_valid;
            assign src_mix   = mix_comb;
            assign src_key   = in_key;
            assign a_busy    = 1'b0;
        end
    endgenerate

    // B captures AddRoundKey of the incoming stage; holds under stall.
    always_comb begin
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        if (b_can_load) begin
            b_valid_d = src_valid;
            if (src_valid) begin
                b_data_d = src_mix ^ src_key;
            end
        end
    end

    // Stage B registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
        end else begin
            b_valid_q <= b_valid_d;
            b_data_q  <= b_data_d;
        end
    end

    assign out_valid = b_valid_q;
    assign out_data  = b_data_q;
    assign busy      = a_busy || b_valid_q;

endmodule

// File: tb/tb_aes_round_tail.sv
// Scoreboard bench for aes_round_tail: both REG_MIX settings, known-answer
// vectors, backpressure, reset mid-flight and a random stream.
module tb_aes_round_tail;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_last;
    logic [127:0] in_data, in_key;
    logic         out_valid, out_ready, busy;
    logic [127:0] out_data;

    logic         z_in_valid, z_in_ready, z_in_last;
    logic [127:0] z_in_data, z_in_key;
    logic         z_out_valid, z_out_ready, z_busy;
    logic [127:0] z_out_data;

    int unsigned  chk_cnt = 0;
    int unsigned  err_cnt = 0;
    logic [127:0] exp_q[$];
    logic         drv_done;

    always #5 clk = ~clk;

    aes_round_tail #(.REG_MIX(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_key(in_key), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    aes_round_tail #(.REG_MIX(0)) dut_comb (
        .clk(clk), .rst(rst),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
        .in_key(z_in_key), .in_last(z_in_last),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
        .busy(z_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: byte-array AES round tail with generic GF multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k, input logic last);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] m[16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) s[i] = d[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                t[row + 4*c] = s[row + 4*((c + row) % 4)];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                m[row + 4*c] = last ? t[row + 4*c] :
                    gmul(8'h02, t[row + 4*c]) ^ gmul(8'h03, t[(row + 1) % 4 + 4*c]) ^
                    t[(row + 2) % 4 + 4*c] ^ t[(row + 3) % 4 + 4*c];
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = m[i] ^ k[127 - 8*i -: 8];
        return r;
    endfunction

    // Present one block, wait (bounded) for acceptance, push its expectation.
    task automatic send_blk(input logic [127:0] d, input logic [127:0] k, input logic l, input logic [127:0] e);
        int n;
        in_valid = 1'b1; in_data = d; in_key = k; in_last = l;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("accept_timeout", {127'd0, in_ready}, 128'd1);
        else exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_key  = {$urandom, $urandom, $urandom, $urandom};
        in_last = 1'($urandom_range(0, 1));
    endtask

    // Output monitor: compare each transferred block against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", {127'd0, out_valid}, 128'd0);
            else check("sb_data", out_data, exp_q.pop_front());
        end
    end

    initial begin
        logic [127:0] kk, b1;
        logic [127:0] bd[4];
        logic [127:0] bk[4];
        int lat, n;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_last = 1'b0; out_ready = 1'b1;
        z_in_valid = 1'b0; z_in_data = '0; z_in_key = '0; z_in_last = 1'b0; z_out_ready = 1'b1;
        drv_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_data", out_data, 128'd0);
        check("rst_comb_in_ready", {127'd0, z_in_ready}, 128'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 round 1 with latency measurement.
        send_blk(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
                 1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_reg", 128'(lat), 128'd2);
        @(posedge clk); #1;

        // ShiftRows only, then zero state.
        kk = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        send_blk(128'h000102030405060708090a0b0c0d0e0f, 128'd0, 1'b1,
                 128'h00050a0f04090e03080d02070c01060b);
        send_blk(128'd0, kk, 1'b0, kk);
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", {127'd0, busy}, 128'd0);

        // Backpressure: two accepts fill the pipe, then hold.
        for (int i = 0; i < 4; i++) begin
            bd[i] = {$urandom, $urandom, $urandom, $urandom};
            bk[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        b1 = ref_round(bd[0], bk[0], 1'b0);
        out_ready = 1'b0;
        send_blk(bd[0], bk[0], 1'b0, b1);
        send_blk(bd[1], bk[1], 1'b0, ref_round(bd[1], bk[1], 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {127'd0, in_ready}, 128'd0);
            check("stall_out_valid", {127'd0, out_valid}, 128'd1);
            check("stall_out_data", out_data, b1);
        end
        fork
            begin
                send_blk(bd[2], bk[2], 1'b1, ref_round(bd[2], bk[2], 1'b1));
                send_blk(bd[3], bk[3], 1'b0, ref_round(bd[3], bk[3], 1'b0));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("drain_back_to_back", {127'd0, out_valid}, 128'd1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_sb_empty", 128'(exp_q.size()), 128'd0);

        // Reset with two blocks in flight.
        send_blk(bd[0], bk[0], 1'b0, b1);
        send_blk(bd[1], bk[1], 1'b0, b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_busy", {127'd0, busy}, 128'd0);
        check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        exp_q.delete();
        rst = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("post_rst_no_stale", 128'(n), 128'd0);
        @(posedge clk); #1;

        // Random stream with random backpressure.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [127:0] d, k;
                    logic l;
                    d = {$urandom, $urandom, $urandom, $urandom};
                    k = {$urandom, $urandom, $urandom, $urandom};
                    l = 1'($urandom_range(0, 3) == 0);
                    send_blk(d, k, l, ref_round(d, k, l));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("rand_drain", 128'(exp_q.size()), 128'd0);

        // Combinational-mix variant: same answer, one cycle sooner.
        z_in_valid = 1'b1;
        z_in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
        z_in_key  = 128'ha0fafe1788542cb123a339392a6c7605;
        z_in_last = 1'b0;
        @(negedge clk);
        check("comb_in_ready", {127'd0, z_in_ready}, 128'd1);
        @(posedge clk); #1;
        z_in_valid = 1'b0;
        z_in_data = '0;
        lat = 1;
        while (!z_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_comb", 128'(lat), 128'd1);
        check("comb_out_data", z_out_data, 128'ha49c7ff2689f352b6b5bea43026a5049);
        @(posedge clk); #1;
        check("comb_idle", {127'd0, z_out_valid}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
